// File: rtl/cnn_pkg.sv
// Shared defaults, error-bit indices and read-FSM state encoding for the CNN frame feeder.
package cnn_pkg;

  localparam int DW   = 32;
  localparam int NPIX = 784;
  localparam int AW   = 10;

  localparam int ERR_FRAME    = 0;
  localparam int ERR_OVERREAD = 1;

  typedef logic [1:0] rd_state_t;

  localparam rd_state_t ST_IDLE      = 2'd0;
  localparam rd_state_t ST_START     = 2'd1;
  localparam rd_state_t ST_STREAM    = 2'd2;
  localparam rd_state_t ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/feeder_bank_ram.sv
// Two-bank simple dual-port RAM, one write and one read port, registered read (latency 1).
module feeder_bank_ram #(
  parameter int W    = 32,
  parameter int NPIX = 784,
  parameter int AW   = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_ptr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_ptr,
  output logic [W-1:0]  rd_data
);

  localparam int IW = $clog2(2 * NPIX);

  logic [W-1:0] mem [0:2*NPIX-1];

  // {bank, ptr} is packed densely so the array is exactly two frames deep.
  function automatic logic [IW-1:0] lin_addr(input logic bank, input logic [AW-1:0] ptr);
    lin_addr = bank ? (IW'(NPIX) + IW'(ptr)) : IW'(ptr);
  endfunction

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[lin_addr(wr_bank, wr_ptr)] <= wr_data;
    end
  end

  // Read port; data holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= {W{1'b0}};
    end else if (rd_en) begin
      rd_data <= mem[lin_addr(rd_bank, rd_ptr)];
    end else begin
      rd_data <= rd_data;
    end
  end

endmodule

// File: rtl/cnn_frame_feeder.sv
// Ping-pong frame buffer between a pixel stream and the CNN pull interface.
// Optional build macro CNN_FEEDER_BIN_PIXEL_EN stores 1-bit binarized pixels.
module cnn_frame_feeder #(
  parameter int                     DW         = cnn_pkg::DW,
  parameter int                     NPIX       = cnn_pkg::NPIX,
  parameter int                     AW         = cnn_pkg::AW,
  parameter logic signed [DW-1:0]   BIN_THRESH = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          cnn_start,
  output logic [DW-1:0] cnn_din,
  output logic          cnn_din_valid,
  input  logic          cnn_din_ready,
  input  logic          cnn_done,
  output logic [1:0]    err,
  output logic [15:0]   frame_cnt
);

  import cnn_pkg::*;

`ifdef CNN_FEEDER_BIN_PIXEL_EN
  localparam int MW = 1;
`else
  localparam int MW = DW;
`endif

  logic [1:0]    full_r;
  logic          wr_bank_r;
  logic          rd_bank_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  rd_state_t     state_r;

  logic          wr_acc_s;
  logic          wr_at_end_s;
  logic          wr_done_s;
  logic          wr_bad_s;
  logic          rd_req_s;
  logic          release_s;
  logic          overread_s;
  logic [1:0]    full_nxt_s;
  logic [MW-1:0] ram_wdata_s;
  logic [MW-1:0] ram_rdata_s;

  assign s_ready = ~full_r[wr_bank_r];

  // Handshake decode and next bank-occupancy; fill and release always target different banks.
  always_comb begin
    wr_acc_s    = s_valid & s_ready;
    wr_at_end_s = (wr_ptr_r == AW'(NPIX - 1));
    wr_done_s   = wr_acc_s & s_last & wr_at_end_s;
    wr_bad_s    = wr_acc_s & (s_last ^ wr_at_end_s);
    rd_req_s    = (state_r == ST_STREAM) & cnn_din_ready & (rd_ptr_r < (AW+1)'(NPIX));
    release_s   = cnn_done & (state_r != ST_IDLE);
    overread_s  = (state_r == ST_WAIT_DONE) & cnn_din_ready;
    full_nxt_s  = (full_r | (wr_done_s ? (2'b01 << wr_bank_r) : 2'b00))
                & ~(release_s ? (2'b01 << rd_bank_r) : 2'b00);
  end

  // Write side: pointer, bank selection, occupancy and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_r    <= 2'b00;
      wr_bank_r <= 1'b0;
      wr_ptr_r  <= {AW{1'b0}};
      err       <= 2'b00;
    end else begin
      full_r <= full_nxt_s;
      if (wr_done_s || wr_bad_s) begin
        wr_ptr_r <= {AW{1'b0}};
      end else if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      wr_bank_r          <= wr_bank_r ^ wr_done_s;
      err[ERR_FRAME]     <= err[ERR_FRAME] | wr_bad_s;
      err[ERR_OVERREAD]  <= err[ERR_OVERREAD] | overread_s;
    end
  end

  // Read FSM; a release from START, STREAM or WAIT_DONE returns straight to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      rd_bank_r     <= 1'b0;
      rd_ptr_r      <= {(AW+1){1'b0}};
      cnn_start     <= 1'b0;
      cnn_din_valid <= 1'b0;
      frame_cnt     <= 16'd0;
    end else begin
      cnn_start     <= 1'b0;
      cnn_din_valid <= rd_req_s;
      if (release_s) begin
        rd_bank_r <= ~rd_bank_r;
        frame_cnt <= frame_cnt + 16'd1;
        state_r   <= ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (full_r[rd_bank_r]) begin
              state_r   <= ST_START;
              cnn_start <= 1'b1;
            end
          end
          ST_START: begin
            rd_ptr_r <= {(AW+1){1'b0}};
            state_r  <= ST_STREAM;
          end
          ST_STREAM: begin
            if (rd_req_s) begin
              rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
              if (rd_ptr_r == (AW+1)'(NPIX - 1)) begin
                state_r <= ST_WAIT_DONE;
              end
            end
          end
          ST_WAIT_DONE: begin
            state_r <= ST_WAIT_DONE;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef CNN_FEEDER_BIN_PIXEL_EN
  logic have_pix_r;

  assign ram_wdata_s = ($signed(s_data) >= BIN_THRESH);

  // Tracks whether the read register holds a real pixel so reset still shows zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      have_pix_r <= 1'b0;
    end else if (rd_req_s) begin
      have_pix_r <= 1'b1;
    end else begin
      have_pix_r <= have_pix_r;
    end
  end

  assign cnn_din = !have_pix_r      ? {DW{1'b0}} :
                   ram_rdata_s[0]   ? {{(DW-1){1'b0}}, 1'b1} :
                                      {DW{1'b1}};
`else
  assign ram_wdata_s = s_data;
  assign cnn_din     = ram_rdata_s;
`endif

  feeder_bank_ram #(
    .W    (MW),
    .NPIX (NPIX),
    .AW   (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc_s),
    .wr_bank (wr_bank_r),
    .wr_ptr  (wr_ptr_r),
    .wr_data (ram_wdata_s),
    .rd_en   (rd_req_s),
    .rd_bank (rd_bank_r),
    .rd_ptr  (rd_ptr_r[AW-1:0]),
    .rd_data (ram_rdata_s)
  );

endmodule

// File: tb/tb_cnn_frame_feeder.sv
// Directed self-checking bench for cnn_frame_feeder (default or binarized build).
module tb_cnn_frame_feeder;

  localparam int DW   = 32;
  localparam int NPIX = 784;
  localparam int AW   = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          cnn_start;
  logic [DW-1:0] cnn_din;
  logic          cnn_din_valid;
  logic          cnn_din_ready;
  logic          cnn_done;
  logic [1:0]    err;
  logic [15:0]   frame_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cnn_frame_feeder #(
    .DW   (DW),
    .NPIX (NPIX),
    .AW   (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_last        (s_last),
    .cnn_start     (cnn_start),
    .cnn_din       (cnn_din),
    .cnn_din_valid (cnn_din_valid),
    .cnn_din_ready (cnn_din_ready),
    .cnn_done      (cnn_done),
    .err           (err),
    .frame_cnt     (frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Stimulus pixel: mode 0 is a ramp from base, mode 1 cycles -5, 0, 7.
  function automatic logic [31:0] gen_pix(input int mode, input int base, input int i);
    logic [31:0] v;
    if (mode == 0) v = base + i;
    else if (i % 3 == 0) v = -32'sd5;
    else if (i % 3 == 1) v = 32'sd0;
    else v = 32'sd7;
    return v;
  endfunction

  function automatic logic [31:0] exp_pix(input logic [31:0] v);
`ifdef CNN_FEEDER_BIN_PIXEL_EN
    return ($signed(v) >= 0) ? 32'sd1 : -32'sd1;
`else
    return v;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    cnn_din_ready = 1'b0; cnn_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_frame(input int mode, input int base, input int len, input int last_at);
    int w;
    for (int i = 0; i < len; i++) begin
      s_valid = 1'b1;
      s_data  = gen_pix(mode, base, i);
      s_last  = (i == last_at);
      w = 0;
      while (!s_ready && w < 5000) begin
        @(negedge clk);
        w++;
      end
      if (w >= 5000) begin
        check("send_timeout", 32'd0, 32'd1);
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
  endtask

  // Pulls one frame, checking values, count and back-to-back delivery.
  task automatic stream_frame(input int mode, input int base, input string tag, output int first_lat);
    int received, bad, gaps, cyc;
    received = 0; bad = 0; gaps = 0; cyc = 0; first_lat = -1;
    cnn_din_ready = 1'b1;
    while (received < NPIX && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cnn_din_valid) begin
        if (first_lat < 0) first_lat = cyc;
        if (cnn_din !== exp_pix(gen_pix(mode, base, received))) bad++;
        received++;
        if (received == NPIX) cnn_din_ready = 1'b0;
      end else if (received > 0) begin
        gaps++;
      end
    end
    cnn_din_ready = 1'b0;
    check({tag, "_count"}, received, NPIX);
    check({tag, "_bad_pixels"}, bad, 0);
    check({tag, "_gaps"}, gaps, 0);
  endtask

  task automatic pulse_done();
    cnn_done = 1'b1;
    @(negedge clk);
    cnn_done = 1'b0;
  endtask

  task automatic wait_start(input int budget, output int seen);
    seen = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (cnn_start) begin
        seen = 1;
        break;
      end
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, seen, cnt, bad;

    // Reset state.
    do_reset();
    check("rst_s_ready", s_ready, 1);
    check("rst_cnn_start", cnn_start, 0);
    check("rst_din_valid", cnn_din_valid, 0);
    check("rst_cnn_din", cnn_din, 0);
    check("rst_err", err, 0);
    check("rst_frame_cnt", frame_cnt, 0);

    // Single frame with exact start timing and latency.
    send_frame(0, 0, NPIX, NPIX - 1);
    check("start_not_early", cnn_start, 0);
    @(negedge clk);
    check("start_pulse", cnn_start, 1);
    @(negedge clk);
    check("start_one_cycle", cnn_start, 0);
    stream_frame(0, 0, "single", lat);
    check("single_latency", lat, 1);
    @(negedge clk);
    check("single_valid_low", cnn_din_valid, 0);
    check("single_din_hold", cnn_din, exp_pix(32'd783));
    check("single_err", err, 0);
    pulse_done();
    check("single_frame_cnt", frame_cnt, 1);

    // Ping-pong: two frames fill both banks, third stalls until a release.
    do_reset();
    send_frame(0, 10000, NPIX, NPIX - 1);
    send_frame(0, 20000, NPIX, NPIX - 1);
    check("pp_sready_full", s_ready, 0);
    s_valid = 1'b1; s_data = gen_pix(0, 30000, 0); s_last = 1'b0;
    repeat (3) @(negedge clk);
    check("pp_stall", s_ready, 0);
    pulse_done();
    check("pp_sready_after_done", s_ready, 1);
    check("pp_cnt1", frame_cnt, 1);
    send_frame(0, 30000, NPIX, NPIX - 1);
    check("pp_err", err, 0);
    check("pp_sready_full2", s_ready, 0);
    stream_frame(0, 20000, "pp_b", lat);
    pulse_done();
    check("pp_cnt2", frame_cnt, 2);
    stream_frame(0, 30000, "pp_c", lat);
    pulse_done();
    check("pp_cnt3", frame_cnt, 3);
    check("pp_sready_end", s_ready, 1);

    // Framing: early s_last, then a good frame still starts at address 0.
    do_reset();
    send_frame(0, 0, 501, 500);
    @(negedge clk);
    check("frame_err_early_last", err, 2'b01);
    wait_start(20, seen);
    check("frame_no_start", seen, 0);
    send_frame(0, 40000, NPIX, NPIX - 1);
    stream_frame(0, 40000, "frame_recover", lat);
    pulse_done();
    check("frame_recover_cnt", frame_cnt, 1);
    check("frame_err_sticky", err, 2'b01);

    // Framing: missing s_last on the final pixel.
    do_reset();
    send_frame(0, 0, NPIX, -1);
    @(negedge clk);
    check("frame_err_missing_last", err, 2'b01);
    wait_start(20, seen);
    check("frame_missing_no_start", seen, 0);

    // Over-read: ready held for 790 cycles.
    do_reset();
    send_frame(0, 50000, NPIX, NPIX - 1);
    wait_start(20, seen);
    check("or_start_seen", seen, 1);
    cnt = 0; bad = 0;
    cnn_din_ready = 1'b1;
    for (int c = 0; c < 790; c++) begin
      @(negedge clk);
      if (cnn_din_valid) begin
        if (cnn_din !== exp_pix(gen_pix(0, 50000, cnt))) bad++;
        cnt++;
      end
    end
    cnn_din_ready = 1'b0;
    @(negedge clk);
    if (cnn_din_valid) cnt++;
    check("or_count", cnt, NPIX);
    check("or_bad_pixels", bad, 0);
    check("or_err", err, 2'b10);
    check("or_valid_low", cnn_din_valid, 0);
    pulse_done();
    check("or_frame_cnt", frame_cnt, 1);

    // Reset in the middle of streaming at rd_ptr=300.
    send_frame(0, 60000, NPIX, NPIX - 1);
    wait_start(20, seen);
    check("mid_start_seen", seen, 1);
    @(negedge clk);
    cnn_din_ready = 1'b1;
    repeat (300) @(negedge clk);
    cnn_din_ready = 1'b0;
    check("mid_din_before_rst", cnn_din, exp_pix(32'd60299));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_s_ready", s_ready, 1);
    check("mid_cnn_start", cnn_start, 0);
    check("mid_din_valid", cnn_din_valid, 0);
    check("mid_cnn_din", cnn_din, 0);
    check("mid_err", err, 0);
    check("mid_frame_cnt", frame_cnt, 0);
    wait_start(20, seen);
    check("mid_no_start", seen, 0);
    send_frame(1, 0, NPIX, NPIX - 1);
    stream_frame(1, 0, "pattern", lat);
    pulse_done();
    check("pattern_frame_cnt", frame_cnt, 1);
    check("pattern_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnn_frame_feeder.md
Name: cnn_frame_feeder

Overview:
- Upstream stage of the CNN classifier. Accepts pixels of 28x28 images on a valid/ready stream and stores whole frames in a ping-pong frame buffer.
- Starts the CNN on each stored frame and serves pixels on its din/din_ready pull interface.
- Frame k+1 can load while frame k is classified.

Parameters:
- DW, 32, pixel width (signed).
- NPIX, 784, pixels per frame.
- AW, 10, pixel address width; must satisfy 2^AW >= NPIX.
- BIN_THRESH, 0, signed binarization threshold (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  feeder can accept a pixel.
- s_data  in  DW  signed pixel.
- s_last  in  1  marks the final pixel of a frame.
- cnn_start  out  1  one-cycle pulse: a frame is available.
- cnn_din  out  DW  pixel to CNN, signed.
- cnn_din_valid  out  1  cnn_din holds a requested pixel this cycle.
- cnn_din_ready  in  1  CNN pixel request, one pixel per high cycle.
- cnn_done  in  1  CNN finished classifying the current frame.
- err  out  2  sticky errors: bit0 framing, bit1 over-read.
- frame_cnt  out  16  frames fully consumed, wraps modulo 2^16.

Behaviour:
- Reset (rst high at posedge):
  - all outputs 0, except s_ready=1;
  - both banks marked empty; wr_bank=0, rd_bank=0;
  - pointers 0; FSM to IDLE.
  - Reset mid-frame discards all buffered data. No partial frame survives.
- Write side:
  - A pixel is accepted when s_valid && s_ready. It is written to bank wr_bank at address wr_ptr, and wr_ptr increments.
  - s_ready = !full[wr_bank].
  - Frame completes on an accepted pixel with wr_ptr==NPIX-1 and s_last=1. Then full[wr_bank] is set, wr_bank toggles and wr_ptr clears, all in the same edge.
  - Framing error (sets err[0], discards the frame, wr_ptr cleared, bank stays empty):
    - s_last=1 with wr_ptr!=NPIX-1;
    - s_last=0 with wr_ptr==NPIX-1.
- Read FSM:
  - IDLE: if full[rd_bank], go to START.
  - START: cnn_start=1 for exactly this cycle; rd_ptr=0; go to STREAM.
  - STREAM: each cycle cnn_din_ready=1 with rd_ptr<NPIX issues a RAM read at rd_ptr and increments rd_ptr.
    - Data appears on cnn_din with cnn_din_valid=1 on the following cycle (latency 1). Back-to-back requests give one pixel per cycle.
    - cnn_din holds its last value when not valid.
    - When rd_ptr reaches NPIX, go to WAIT_DONE.
  - WAIT_DONE: on cnn_done, clear full[rd_bank], toggle rd_bank, increment frame_cnt, go to IDLE.
    - In IDLE, the next full bank starts at the earliest on the cycle after.
  - cnn_done in START or STREAM is treated the same as in WAIT_DONE: the frame is released immediately.
  - cnn_din_ready in WAIT_DONE or IDLE is ignored (cnn_din_valid=0). In WAIT_DONE it also sets err[1].
- Simultaneous events:
  - A write completion and a read release always hit different banks; both take effect in the same edge.
  - If the write side fills the bank that is released in the same cycle, that is legal. s_ready rises the next cycle.
- err bits clear only on rst.

Optional Feature:
- Macro: CNN_FEEDER_BIN_PIXEL_EN.
- Defined:
  - The bank RAM stores 1 bit per pixel: bit = (s_data >= BIN_THRESH).
  - cnn_din = bit ? +1 : -1, sign-extended to DW (32'sd1 / -32'sd1).
- Undefined: full DW-bit pixels are stored and returned unchanged; BIN_THRESH is unused.

Decomposition:
- Package cnn_pkg holds:
  - DW, NPIX, AW defaults;
  - err bit indices ERR_FRAME=0, ERR_OVERREAD=1;
  - the read-FSM state enum IDLE/START/STREAM/WAIT_DONE.
- One sub-module, feeder_bank_ram:
  - simple dual-port synchronous RAM, 2*NPIX deep, address {bank, ptr};
  - width 1 or DW per the macro;
  - one write port, one read port, read latency 1.

Test Plan:
- Single frame: write pixels 0..783 (s_last on 783), CNN holds din_ready high for 784 cycles.
  - Expect cnn_start pulse 1 cycle after the last write enters IDLE→START.
  - Expect cnn_din = 0..783 contiguous, each 1 cycle after its request.
  - After cnn_done, expect frame_cnt=1.
- Ping-pong: stream 3 frames back-to-back with no CNN activity.
  - s_ready drops after pixel 1567 (both banks full). Third-frame pixel 0 is stalled.
  - After one cnn_done, s_ready=1 the next cycle.
- Framing: s_last at pixel 500.
  - Expect err=2'b01 and no cnn_start.
  - The next correct 784-pixel frame still starts normally at address 0.
- Over-read: din_ready high for 790 cycles.
  - Exactly 784 valid pixels, then err[1]=1 and cnn_din_valid stays 0.
- Reset mid-STREAM at rd_ptr=300.
  - Next cycle all outputs reset and s_ready=1; no cnn_start until a new full frame is written.
- CNN_FEEDER_BIN_PIXEL_EN, BIN_THRESH=0: pixels -5, 0, 7.
  - Expect cnn_din = -1, +1, +1.
